// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART transmitter among NUM_SRC byte sources.
// Round-robin between frames, grant held for a whole frame, busy-timeout watchdog.
//
//   state     | meaning
//   ----------+------------------------------------------------------------
//   IDLE      | no byte in flight; pick a candidate (locked source only if mid-frame)
//   WAIT_BUSY | tx_start issued; waiting for the transmitter to raise tx_busy
//   WAIT_DONE | transmitter busy; waiting for tx_busy to fall
module uart_tx_arbiter #(
  parameter int NUM_SRC      = 4,
  parameter int BUSY_TIMEOUT = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [NUM_SRC-1:0]   i_req_valid,
  input  logic [NUM_SRC*8-1:0] i_req_data,
  input  logic [NUM_SRC-1:0]   i_req_last,
  output logic [NUM_SRC-1:0]   o_req_ready,
  output logic [NUM_SRC-1:0]   o_grant,
  output logic                 o_tx_start,
  output logic [7:0]           o_tx_data,
  input  logic                 i_tx_busy,
  output logic                 o_arb_busy,
  output logic                 o_err_timeout
);

  localparam int         IW       = $clog2(NUM_SRC);
  localparam logic [7:0] CNT_LAST = 8'(BUSY_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, WAIT_BUSY, WAIT_DONE} state_t;

  state_t             r_state, w_state;
  logic               r_lock, w_lock;
  logic [IW-1:0]      r_owner, w_owner;
  logic [IW-1:0]      r_last_owner, w_last_owner;
  logic               r_last, w_last;
  logic [7:0]         r_cnt, w_cnt;
  logic               r_tx_start, w_tx_start;
  logic [7:0]         r_tx_data, w_tx_data;
  logic [NUM_SRC-1:0] r_req_ready, w_req_ready;
  logic [NUM_SRC-1:0] r_grant, w_grant;
  logic               r_err, w_err;

  logic [NUM_SRC-1:0] w_cand;
  logic               w_found;
  logic [IW-1:0]      w_sel;
  logic [NUM_SRC-1:0] w_onehot;
  logic [7:0]         w_lane_data;
  logic               w_lane_last;

  // Round-robin pick starting after last_owner; while locked the held grant masks everyone else
  always_comb begin
    w_cand  = r_lock ? (i_req_valid & r_grant) : i_req_valid;
    w_found = 1'b0;
    w_sel   = '0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (!w_found && w_cand[i] && (i == (int'(r_last_owner) + k) % NUM_SRC)) begin
          w_found = 1'b1;
          w_sel   = IW'(i);
        end
      end
    end
  end

  // Lane mux for the selected source's byte and last flag
  always_comb begin
    w_lane_data = 8'h00;
    w_lane_last = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (w_sel == IW'(i)) begin
        w_lane_data = i_req_data[i*8 +: 8];
        w_lane_last = i_req_last[i];
      end
    end
  end

  assign w_onehot = {{(NUM_SRC-1){1'b0}}, 1'b1} << w_sel;

  // Next-state and output decode
  always_comb begin
    w_state      = r_state;
    w_lock       = r_lock;
    w_owner      = r_owner;
    w_last_owner = r_last_owner;
    w_last       = r_last;
    w_cnt        = r_cnt;
    w_tx_data    = r_tx_data;
    w_grant      = r_grant;
    w_tx_start   = 1'b0;
    w_req_ready  = '0;
    w_err        = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_found) begin
          w_state     = WAIT_BUSY;
          w_tx_start  = 1'b1;
          w_req_ready = w_onehot;
          w_grant     = w_onehot;
          w_tx_data   = w_lane_data;
          w_last      = w_lane_last;
          w_owner     = w_sel;
          w_cnt       = 8'h00;
        end
      end
      WAIT_BUSY: begin
        if (i_tx_busy) begin
          w_state = WAIT_DONE;
        end else if (r_cnt == CNT_LAST) begin
          // Transmitter never answered: abandon the frame so others are not starved
          w_err        = 1'b1;
          w_lock       = 1'b0;
          w_grant      = '0;
          w_last_owner = r_owner;
          w_state      = IDLE;
        end else begin
          w_cnt = r_cnt + 8'h01;
        end
      end
      WAIT_DONE: begin
        if (!i_tx_busy) begin
          w_state = IDLE;
          if (r_last) begin
            w_lock       = 1'b0;
            w_grant      = '0;
            w_last_owner = r_owner;
          end else begin
            w_lock = 1'b1;
          end
        end
      end
      default: w_state = IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= IDLE;
      r_lock       <= 1'b0;
      r_owner      <= '0;
      r_last_owner <= IW'(NUM_SRC - 1);
      r_last       <= 1'b0;
      r_cnt        <= 8'h00;
      r_tx_start   <= 1'b0;
      r_tx_data    <= 8'h00;
      r_req_ready  <= '0;
      r_grant      <= '0;
      r_err        <= 1'b0;
    end else begin
      r_state      <= w_state;
      r_lock       <= w_lock;
      r_owner      <= w_owner;
      r_last_owner <= w_last_owner;
      r_last       <= w_last;
      r_cnt        <= w_cnt;
      r_tx_start   <= w_tx_start;
      r_tx_data    <= w_tx_data;
      r_req_ready  <= w_req_ready;
      r_grant      <= w_grant;
      r_err        <= w_err;
    end
  end

  assign o_req_ready   = r_req_ready;
  assign o_grant       = r_grant;
  assign o_tx_start    = r_tx_start;
  assign o_tx_data     = r_tx_data;
  assign o_arb_busy    = (r_state != IDLE);
  assign o_err_timeout = r_err;

endmodule
